// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing, derived totals/sync windows and the
// 3-bit to 24-bit colour expansion shared by the scan generator.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DEF_H_DISP = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_V_DISP = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;

    localparam int unsigned DEF_H_TOTAL  = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned DEF_HS_START = DEF_H_DISP + DEF_H_FP;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int unsigned DEF_VS_START = DEF_V_DISP + DEF_V_FP;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // Each colour bit saturates its whole 8-bit channel.
    function automatic logic [23:0] expand_rgb(input logic [2:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Modulo-MAX counter advancing on en; wrap flags the MAX-1 -> 0 step.
module scan_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned MAX = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == CNT_W'(MAX - 1));
    assign wrap   = en && at_max;
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel divider, h/v counters, sync windows and a
// pix_tick-aligned registered output stage for the HDMI encoder.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISP  = DEF_H_DISP,
    parameter int unsigned H_FP    = DEF_H_FP,
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BP    = DEF_H_BP,
    parameter int unsigned V_DISP  = DEF_V_DISP,
    parameter int unsigned V_FP    = DEF_V_FP,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BP    = DEF_V_BP,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    parameter int unsigned CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             video_on,
    output logic             pix_tick,
    output logic             frame_tick,
    input  logic             graph_on,
    input  logic [2:0]       graph_rgb,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [23:0]      rgb_o
);

    localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_DISP + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISP + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             div_wrap;
    logic             h_wrap;
    logic             v_wrap;
    logic             unused_bits_c;

    scan_counter #(.MAX(CLK_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .cnt   (div_cnt),
        .wrap  (div_wrap)
    );

    scan_counter #(.MAX(H_TOTAL)) u_h (
        .clk   (clk),
        .reset (reset),
        .en    (pix_tick),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    scan_counter #(.MAX(V_TOTAL)) u_v (
        .clk   (clk),
        .reset (reset),
        .en    (h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap)
    );

    // Divider count and frame wrap are only needed inside the counters.
    assign unused_bits_c = ^{div_cnt, v_wrap};

    assign pix_tick   = div_wrap;
    assign pix_x      = h_cnt;
    assign pix_y      = v_cnt;
    assign video_on   = (h_cnt < CNT_W'(H_DISP)) && (v_cnt < CNT_W'(V_DISP));
    assign frame_tick = pix_tick && (h_cnt == '0) && (v_cnt == CNT_W'(V_DISP + 1));

    logic        hs_win_c;
    logic        vs_win_c;
    logic [23:0] pix_rgb_c;

    assign hs_win_c  = (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END));
    assign vs_win_c  = (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END));
    assign pix_rgb_c = (video_on && graph_on) ? expand_rgb(graph_rgb) : 24'h000000;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [23:0] rgb_q, rgb_d;

    // Output stage: sample the current pixel once per pix_tick, hold otherwise.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        rgb_d   = rgb_q;
        if (pix_tick) begin
            hsync_d = hs_win_c ^ ~HS_POL;
            vsync_d = vs_win_c ^ ~VS_POL;
            de_d    = video_on;
            rgb_d   = pix_rgb_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            rgb_q   <= 24'h000000;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign de_o    = de_q;
    assign rgb_o   = rgb_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: default-timing instance plus two reduced
// rasters (CLK_DIV=1 and CLK_DIV=4, active-high syncs) for frame-level checks.
module tb_vga_scan_gen;

    // Reduced raster: H_TOTAL=24, V_TOTAL=13, frame = 312 pixels.
    localparam int unsigned S_HD = 16, S_HF = 2, S_HS = 4, S_HB = 2;
    localparam int unsigned S_VD = 8,  S_VF = 1, S_VS = 2, S_VB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, rst_s;

    logic [9:0]  d_x, d_y;
    logic        d_von, d_pt, d_ft, d_hs, d_vs, d_de;
    logic [23:0] d_rgb_o;
    logic        d_on;
    logic [2:0]  d_rgb;

    logic [9:0]  s1_x, s1_y;
    logic        s1_von, s1_pt, s1_ft, s1_hs, s1_vs, s1_de;
    logic [23:0] s1_rgb_o;

    logic [9:0]  s4_x, s4_y;
    logic        s4_von, s4_pt, s4_ft, s4_hs, s4_vs, s4_de;
    logic [23:0] s4_rgb_o;

    vga_scan_gen u_def (
        .clk(clk), .reset(rst_d), .pix_x(d_x), .pix_y(d_y), .video_on(d_von),
        .pix_tick(d_pt), .frame_tick(d_ft), .graph_on(d_on), .graph_rgb(d_rgb),
        .hsync_o(d_hs), .vsync_o(d_vs), .de_o(d_de), .rgb_o(d_rgb_o)
    );

    vga_scan_gen #(
        .H_DISP(S_HD), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_DISP(S_VD), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1)
    ) u_s1 (
        .clk(clk), .reset(rst_s), .pix_x(s1_x), .pix_y(s1_y), .video_on(s1_von),
        .pix_tick(s1_pt), .frame_tick(s1_ft), .graph_on(1'b0), .graph_rgb(3'b000),
        .hsync_o(s1_hs), .vsync_o(s1_vs), .de_o(s1_de), .rgb_o(s1_rgb_o)
    );

    vga_scan_gen #(
        .H_DISP(S_HD), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_DISP(S_VD), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(4)
    ) u_s4 (
        .clk(clk), .reset(rst_s), .pix_x(s4_x), .pix_y(s4_y), .video_on(s4_von),
        .pix_tick(s4_pt), .frame_tick(s4_ft), .graph_on(1'b1), .graph_rgb(3'b111),
        .hsync_o(s4_hs), .vsync_o(s4_vs), .de_o(s4_de), .rgb_o(s4_rgb_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic wait_xy_d(input int x, input int y, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (32'(d_x) == x && 32'(d_y) == y) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout(name);
    endtask

    // Line-0 hsync after a reset release: first low registered from h=656, 96 clks wide.
    task automatic hsync_run(input string name);
        int n;
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (d_hs == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            timeout({name, "_start"});
            return;
        end
        check({name, "_first_x"}, 32'(d_x), 32'd657);
        check({name, "_first_y"}, 32'(d_y), 32'd0);
        n = 0;
        while (d_hs == 1'b0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check({name, "_width"}, 32'(n), 32'd96);
    endtask

    typedef struct {
        int          x;
        int          y;
        logic        on;
        logic [2:0]  rgb;
        logic        exp_de;
        logic        exp_hs;
        logic [23:0] exp_rgb;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;

        tbl[0] = '{10,  10, 1'b1, 3'b110, 1'b1, 1'b1, 24'hFFFF00};
        tbl[1] = '{11,  10, 1'b1, 3'b001, 1'b1, 1'b1, 24'h0000FF};
        tbl[2] = '{12,  10, 1'b0, 3'b111, 1'b1, 1'b1, 24'h000000};
        tbl[3] = '{639, 10, 1'b1, 3'b101, 1'b1, 1'b1, 24'hFF00FF};
        tbl[4] = '{640, 10, 1'b1, 3'b111, 1'b0, 1'b1, 24'h000000};
        tbl[5] = '{700, 10, 1'b1, 3'b110, 1'b0, 1'b0, 24'h000000};
        tbl[6] = '{5,   11, 1'b1, 3'b111, 1'b1, 1'b1, 24'hFFFFFF};
        tbl[7] = '{751, 11, 1'b1, 3'b111, 1'b0, 1'b0, 24'h000000};
        tbl[8] = '{752, 11, 1'b1, 3'b111, 1'b0, 1'b1, 24'h000000};

        rst_d = 1'b0;
        rst_s = 1'b0;
        d_on  = 1'b0;
        d_rgb = 3'b000;
        repeat (3) @(negedge clk);

        check("rst_d_hsync", 32'(d_hs), 32'd1);
        check("rst_d_vsync", 32'(d_vs), 32'd1);
        check("rst_d_de",    32'(d_de), 32'd0);
        check("rst_d_rgb",   32'(d_rgb_o), 32'd0);
        check("rst_d_pixtick", 32'(d_pt), 32'd1);
        check("rst_d_frametick", 32'(d_ft), 32'd0);
        check("rst_s4_hsync", 32'(s4_hs), 32'd0);
        check("rst_s4_vsync", 32'(s4_vs), 32'd0);
        check("rst_s4_pixtick", 32'(s4_pt), 32'd0);

        rst_d = 1'b1;
        rst_s = 1'b1;
        #1;
        check("rel_pix_x", 32'(d_x), 32'd0);
        check("rel_pix_y", 32'(d_y), 32'd0);

        hsync_run("hs_free");

        for (int i = 0; i < 9; i++) begin
            wait_xy_d(tbl[i].x, tbl[i].y, $sformatf("vec%0d_wait", i));
            d_on  = tbl[i].on;
            d_rgb = tbl[i].rgb;
            @(negedge clk);
            check($sformatf("vec%0d_de", i),    32'(d_de),    32'(tbl[i].exp_de));
            check($sformatf("vec%0d_hsync", i), 32'(d_hs),    32'(tbl[i].exp_hs));
            check($sformatf("vec%0d_rgb", i),   32'(d_rgb_o), 32'(tbl[i].exp_rgb));
        end

        // Mid-frame reset while output stage carries a lit pixel.
        d_on  = 1'b1;
        d_rgb = 3'b111;
        wait_xy_d(300, 12, "midrst_wait");
        check("midrst_pre_de", 32'(d_de), 32'd1);
        rst_d = 1'b0;
        #1;
        check("midrst_hsync", 32'(d_hs), 32'd1);
        check("midrst_vsync", 32'(d_vs), 32'd1);
        check("midrst_de",    32'(d_de), 32'd0);
        check("midrst_rgb",   32'(d_rgb_o), 32'd0);
        check("midrst_x",     32'(d_x), 32'd0);
        check("midrst_y",     32'(d_y), 32'd0);
        repeat (2) @(negedge clk);
        rst_d = 1'b1;
        #1;
        check("midrst_rel_x", 32'(d_x), 32'd0);
        check("midrst_rel_y", 32'(d_y), 32'd0);
        hsync_run("hs_after_rst");

        // Reduced raster, CLK_DIV=1: vsync window spans exactly two lines.
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (s1_vs == 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("s1_vs_idle");
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (s1_vs == 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("s1_vs_start");
        check("s1_vs_first_y", 32'(s1_y), 32'd9);
        check("s1_vs_first_x", 32'(s1_x), 32'd1);
        n = 0;
        while (s1_vs == 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("s1_vs_width", 32'(n), 32'd48);

        // Frame tick period and width, CLK_DIV=1.
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (s1_ft == 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("s1_ft_first");
        check("s1_ft_y", 32'(s1_y), 32'd9);
        check("s1_ft_x", 32'(s1_x), 32'd0);
        @(negedge clk);
        check("s1_ft_width", 32'(s1_ft), 32'd0);
        n = 1;
        while (s1_ft !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("s1_ft_period", 32'(n), 32'd312);

        // CLK_DIV=4: pix_tick cadence, frame period and active-high hsync.
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s4_pt == 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("s4_pt_first");
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (s4_pt !== 1'b1 && n < 20);
            check($sformatf("s4_pt_gap%0d", k), 32'(n), 32'd4);
        end

        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (s4_ft == 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("s4_ft_first");
        check("s4_ft_y", 32'(s4_y), 32'd9);
        @(negedge clk);
        check("s4_ft_width", 32'(s4_ft), 32'd0);
        n = 1;
        while (s4_ft !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("s4_ft_period", 32'(n), 32'd1248);

        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s4_hs == 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("s4_hs_idle");
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s4_hs == 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("s4_hs_start");
        check("s4_hs_first_x", 32'(s4_x), 32'd19);
        n = 0;
        while (s4_hs == 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("s4_hs_width", 32'(n), 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Video scan generator that drives the pixel-coordinate side of the display pipeline. It runs the horizontal and vertical raster counters and publishes `pix_x`/`pix_y`, `video_on`, `pix_tick` and a once-per-frame `frame_tick` to the game/graphics blocks. It takes back their combinational `graph_on`/`graph_rgb` answer and emits pixel-aligned, registered `hsync_o`/`vsync_o`/`de_o`/`rgb_o` for the HDMI encoder.

## Interface
Parameters:
- `H_DISP`, default 640: visible pixels per line.
- `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal porch and sync widths; H_TOTAL = 800.
- `V_DISP`, default 480: visible lines.
- `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical porch and sync widths; V_TOTAL = 525.
- `HS_POL`, default 0: hsync active level (0 = active-low).
- `VS_POL`, default 0: vsync active level.
- `CLK_DIV`, default 1: clk cycles per pixel, range 1..16.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-low.
- `pix_x` out 10: current horizontal count, 0..H_TOTAL-1.
- `pix_y` out 10: current vertical count, 0..V_TOTAL-1.
- `video_on` out 1: (pix_x < H_DISP) && (pix_y < V_DISP).
- `pix_tick` out 1: pixel-enable strobe.
- `frame_tick` out 1: one-clk pulse per frame.
- `graph_on` in 1: graphics layer covers the current pixel.
- `graph_rgb` in 3: colour from the graphics layer, {R,G,B}.
- `hsync_o`, `vsync_o`, `de_o` out 1: registered sync and data-enable.
- `rgb_o` out 24: registered {R[7:0],G[7:0],B[7:0]}.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1. `pix_tick` = (div_cnt == CLK_DIV-1). With CLK_DIV=1, `pix_tick` is held at 1.
- Horizontal counter `h_cnt` advances on `pix_tick` and wraps from H_TOTAL-1 to 0.
- On that wrap, vertical counter `v_cnt` advances, wrapping from V_TOTAL-1 to 0.
- `pix_x` = h_cnt and `pix_y` = v_cnt, driven directly from the counter registers.
- Sync active windows:
  - hsync active while H_DISP+H_FP ≤ h_cnt < H_DISP+H_FP+H_SYNC (656..751 at defaults).
  - vsync active while V_DISP+V_FP ≤ v_cnt < V_DISP+V_FP+V_SYNC (490..491).
- `frame_tick` = pix_tick && h_cnt==0 && v_cnt==V_DISP+1. It is combinational, exactly one clk wide, and occurs once per frame.
- Pixel colour:
  - If video_on && graph_on: each graph_rgb bit expands to 8'hFF (bit set) or 8'h00 (bit clear).
  - Otherwise the colour is 24'h000000.
- Output stage updates only on `pix_tick`:
  - `hsync_o`/`vsync_o` take the window state XOR ~POL, so that active equals POL.
  - `de_o` takes video_on; `rgb_o` takes the pixel colour.
- Reset values:
  - div_cnt, h_cnt, v_cnt = 0.
  - `hsync_o` = ~HS_POL, `vsync_o` = ~VS_POL.
  - `de_o` = 0, `rgb_o` = 0.
  - `frame_tick` = 0 and `pix_tick` = 0, except `pix_tick` = 1 when CLK_DIV = 1.
- Reset mid-frame: all state clears immediately and outputs go to their reset values. The first pix_tick after deassertion advances from (0,0).

## Timing
- Latency: `pix_x`/`pix_y` to `hsync_o`/`vsync_o`/`de_o`/`rgb_o` is exactly one pix_tick. Syncs and colour stay mutually aligned.
- `graph_on`/`graph_rgb` are sampled in the same clk as the pix_tick that samples the coordinates. The upstream logic must be combinational from `pix_x`/`pix_y`.
- Line = H_TOTAL pix_ticks; frame = H_TOTAL*V_TOTAL pix_ticks = 420000. The `frame_tick` period is 420000*CLK_DIV clks.
- Outputs hold their value between pix_ticks.
- Counter widths: 10 bits, with no overflow for totals ≤ 1023. Parameter sets with H_TOTAL or V_TOTAL > 1023 are illegal.

## Structure
- `vga_timing_pkg`: default timing constants, derived H_TOTAL/V_TOTAL and sync start/end values, and the 3-bit to 24-bit colour expansion function.
- Sub-module `scan_counter` (parameter MAX; inputs en, clk, reset; outputs cnt, wrap). It is instantiated three times: divider, horizontal, vertical.

## Test plan
- Reset held low, then released (defaults):
  - While low: hsync_o=1, vsync_o=1, de_o=0, rgb_o=0.
  - First cycle after release: pix_x=0, pix_y=0.
- Free run, CLK_DIV=1:
  - hsync_o low for exactly 96 consecutive clks, the first registered from h_cnt=656.
  - vsync_o low for exactly 2 lines, the first registered from v_cnt=490.
- Tie graph_on=1, graph_rgb=3'b110:
  - Pixel (10,10) gives rgb_o=24'hFFFF00 and de_o=1 one tick later.
  - Pixel (700,10) gives rgb_o=0 and de_o=0.
- Frame period check:
  - CLK_DIV=1: successive frame_tick pulses are 420000 clks apart, each 1 clk wide.
  - CLK_DIV=4: pulses are 1680000 clks apart; pix_tick fires every 4th clk.
- Assert reset at pixel (300,200) mid-frame:
  - Outputs return to reset values asynchronously.
  - After release, pix_x/pix_y restart at (0,0) and the hsync timing matches the free-run check.
